// File: rtl/a5_pkg.sv
// A5/1 shared constants: register geometry, feedback taps, clocking bits and sequencer states.
// Pure definitions, no logic; imported by the LFSR datapath and the keystream sequencer.
package a5_pkg;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;   // bits 13,16,17,18
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;  // bits 20,21
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;  // bits 7,20,21,22

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  localparam int KEY_CYCLES   = 64;
  localparam int FRAME_CYCLES = 22;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_FRAME = 3'd2,
    ST_MIX   = 3'd3,
    ST_GEN   = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_lfsr_core.sv
// R1-R3 register datapath: step-all with bit injection, or majority-clocked step; no sequencing.
// ks_bit is combinational from the post-step register values, so it is the bit produced by this cycle's step.
module a5_lfsr_core
  import a5_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic step_all,
  input  logic step_maj,
  input  logic inject,
  output logic ks_bit
);

  logic [R1_LEN-1:0] r1_q, r1_d;
  logic [R2_LEN-1:0] r2_q, r2_d;
  logic [R3_LEN-1:0] r3_q, r3_d;
  logic maj, s1, s2, s3, inj;

  always_comb begin
    maj = maj3(r1_q[R1_CLK], r2_q[R2_CLK], r3_q[R3_CLK]);
    s1  = step_all | (step_maj & (r1_q[R1_CLK] == maj));
    s2  = step_all | (step_maj & (r2_q[R2_CLK] == maj));
    s3  = step_all | (step_maj & (r3_q[R3_CLK] == maj));
    // Injection only applies during the key/frame loading steps.
    inj = step_all & inject;

    r1_d = r1_q;
    r2_d = r2_q;
    r3_d = r3_q;
    if (s1) r1_d = {r1_q[R1_LEN-2:0], (^(r1_q & R1_TAPS)) ^ inj};
    if (s2) r2_d = {r2_q[R2_LEN-2:0], (^(r2_q & R2_TAPS)) ^ inj};
    if (s3) r3_d = {r3_q[R3_LEN-2:0], (^(r3_q & R3_TAPS)) ^ inj};

    ks_bit = r1_d[R1_LEN-1] ^ r2_d[R2_LEN-1] ^ r3_d[R3_LEN-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else if (clear) begin
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
    end
  end

endmodule

// File: rtl/a5_keystream_gen.sv
// A5/1 keystream sequencer: key/frame/mix init then KS_BITS bits packed MSB-first into 32-bit words.
// First word 218 cycles after load; a blocked word hand-off stalls generation until out_ready.
module a5_keystream_gen
  import a5_pkg::*;
#(
  parameter int KS_BITS    = 228,
  parameter int MIX_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  output logic        busy,
  output logic        done,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int BW = $clog2(KS_BITS + 1);

  state_t        state_q, state_d;
  logic [7:0]    cyc_q, cyc_d;
  logic [63:0]   key_q, key_d;
  logic [21:0]   frame_q, frame_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [31:0]   acc_q, acc_d, new_acc, data_d;
  logic          valid_d, done_d;
  logic          core_clear, step_all, step_maj, inject, ks_bit;
  logic          word_end, can_xfer, accept;

  assign busy = (state_q != ST_IDLE);

  a5_lfsr_core u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (core_clear),
    .step_all (step_all),
    .step_maj (step_maj),
    .inject   (inject),
    .ks_bit   (ks_bit)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    key_d      = key_q;
    frame_d    = frame_q;
    bit_d      = bit_q;
    acc_d      = acc_q;
    data_d     = out_data;
    valid_d    = out_valid;
    done_d     = 1'b0;
    core_clear = 1'b0;
    step_all   = 1'b0;
    step_maj   = 1'b0;
    inject     = 1'b0;
    accept     = out_valid & out_ready;
    can_xfer   = ~out_valid | out_ready;
    word_end   = (bit_q[4:0] == 5'd31) || (bit_q == BW'(KS_BITS - 1));
    new_acc    = {acc_q[30:0], ks_bit};

    if (load) begin
      // A load always restarts cleanly, discarding any word still pending.
      state_d    = ST_KEY;
      cyc_d      = '0;
      key_d      = key;
      frame_d    = frame;
      bit_d      = '0;
      acc_d      = '0;
      data_d     = '0;
      valid_d    = 1'b0;
      core_clear = 1'b1;
    end else begin
      case (state_q)
        ST_KEY: begin
          step_all = 1'b1;
          inject   = key_q[0];
          key_d    = key_q >> 1;
          cyc_d    = cyc_q + 8'd1;
          if (cyc_q == 8'(KEY_CYCLES - 1)) begin
            state_d = ST_FRAME;
            cyc_d   = '0;
          end
        end
        ST_FRAME: begin
          step_all = 1'b1;
          inject   = frame_q[0];
          frame_d  = frame_q >> 1;
          cyc_d    = cyc_q + 8'd1;
          if (cyc_q == 8'(FRAME_CYCLES - 1)) begin
            state_d = ST_MIX;
            cyc_d   = '0;
          end
        end
        ST_MIX: begin
          step_maj = 1'b1;
          cyc_d    = cyc_q + 8'd1;
          if (cyc_q == 8'(MIX_CYCLES - 1)) begin
            state_d = ST_GEN;
            cyc_d   = '0;
          end
        end
        ST_GEN: begin
          if (accept) valid_d = 1'b0;
          if (bit_q != BW'(KS_BITS)) begin
            // Only a word-completing bit needs the output register free.
            if (!word_end || can_xfer) begin
              step_maj = 1'b1;
              bit_d    = bit_q + BW'(1);
              if (word_end) begin
                data_d  = new_acc << (5'd31 - bit_q[4:0]);
                valid_d = 1'b1;
                acc_d   = '0;
              end else begin
                acc_d = new_acc;
              end
            end
          end else if (accept) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      key_q     <= '0;
      frame_q   <= '0;
      bit_q     <= '0;
      acc_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      key_q     <= key_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      acc_q     <= acc_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_a5_keystream_gen.sv
// Scoreboard bench for a5_keystream_gen: directed vectors, expected words queued at load, checked by a monitor.
module tb_a5_keystream_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [63:0] key = '0;
  logic [21:0] frame = '0;
  logic        busy, done, out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int word_cnt = 0;
  int bp_cyc = 0;
  bit bp_mode = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] last_word = '0;
  logic [31:0] data_prev = '0;
  logic        stall_prev = 1'b0;

  localparam logic [63:0] KEY_A   = 64'hEFCDAB8967452312;
  localparam logic [21:0] FRAME_A = 22'h134;
  localparam logic [63:0] KEY_B   = 64'h0123456789ABCDEF;
  localparam logic [21:0] FRAME_B = 22'h2A5F3;

  always #5 clk = ~clk;

  a5_keystream_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .key       (key),
    .frame     (frame),
    .busy      (busy),
    .done      (done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%h required=nothing", name, act);
  endtask

  // Reference A5/1 written in the classic software form: 32-bit words, masks, parity.
  function automatic logic [31:0] lstep(input logic [31:0] r, input logic [31:0] taps,
                                        input logic [31:0] m);
    return ((r << 1) & m) | {31'b0, ^(r & taps)};
  endfunction

  function automatic logic [0:7][31:0] a5_ref(input logic [63:0] k, input logic [21:0] f);
    logic [31:0] r1, r2, r3;
    logic [0:7][31:0] w;
    logic b, c1, c2, c3, m;
    int n;
    r1 = '0; r2 = '0; r3 = '0; w = '0;
    for (int i = 0; i < 86; i++) begin
      r1 = lstep(r1, 32'h072000, 32'h07FFFF);
      r2 = lstep(r2, 32'h300000, 32'h3FFFFF);
      r3 = lstep(r3, 32'h700080, 32'h7FFFFF);
      b = (i < 64) ? k[i] : f[i-64];
      r1[0] = r1[0] ^ b;
      r2[0] = r2[0] ^ b;
      r3[0] = r3[0] ^ b;
    end
    for (int i = 0; i < 328; i++) begin
      c1 = r1[8]; c2 = r2[10]; c3 = r3[10];
      m = (c1 & c2) | (c1 & c3) | (c2 & c3);
      if (c1 == m) r1 = lstep(r1, 32'h072000, 32'h07FFFF);
      if (c2 == m) r2 = lstep(r2, 32'h300000, 32'h3FFFFF);
      if (c3 == m) r3 = lstep(r3, 32'h700080, 32'h7FFFFF);
      if (i >= 100) begin
        n = i - 100;
        w[n/32][31 - (n % 32)] = r1[18] ^ r2[21] ^ r3[22];
      end
    end
    return w;
  endfunction

  // Monitor: a handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (reset_n && !load) begin
      if (stall_prev) begin
        check("stall_valid_held", {31'b0, out_valid}, 32'd1);
        check("stall_data_stable", out_data, data_prev);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_msg("unexpected_word", out_data);
        else check("word", out_data, exp_q.pop_front());
        last_word <= out_data;
        word_cnt  <= word_cnt + 1;
      end
      if (done) begin
        check("busy_low_at_done", {31'b0, busy}, 32'd0);
        done_cnt <= done_cnt + 1;
      end
      stall_prev <= out_valid && !out_ready;
      data_prev  <= out_data;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  // Sole driver of out_ready: always high, or random with a 50-cycle hold-off mid word 1.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      bp_cyc++;
      if (bp_cyc >= 240 && bp_cyc < 290) out_ready = 1'b0;
      else out_ready = 1'($urandom_range(0, 1));
    end else begin
      bp_cyc = 0;
      out_ready = 1'b1;
    end
  end

  task automatic push_words(input logic [0:7][31:0] w);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
  endtask

  task automatic pulse_load(input logic [63:0] k, input logic [21:0] f);
    @(posedge clk); #1;
    key = k; frame = f; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic run_to_done(input string name, input int start_done);
    int n = 0;
    while (done_cnt == start_done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_done_once"}, done_cnt - start_done, 32'd1);
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    check({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [0:7][31:0] w;
    int d0, n, w0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_data", out_data, 32'd0);
    reset_n = 1'b1;

    // Known vector, out_ready held high.
    w = a5_ref(KEY_A, FRAME_A);
    w[0] = 32'h534EAA58; w[1] = 32'h2FE8151A; w[2] = 32'hB6E1855A; w[3] = 32'h728C093F;
    push_words(w);
    d0 = done_cnt;
    pulse_load(KEY_A, FRAME_A);
    n = 0;
    while (!out_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_valid_latency", n, 32'd218);
    run_to_done("known", d0);
    check("pad_bits_zero", {4'b0, last_word[27:0]}, 32'd0);

    // Backpressure: same vector, random ready plus a long hold-off.
    push_words(w);
    d0 = done_cnt;
    bp_mode = 1'b1;
    pulse_load(KEY_A, FRAME_A);
    run_to_done("backpressure", d0);
    bp_mode = 1'b0;

    // Restart during MIX: only run B may appear and finish.
    d0 = done_cnt;
    pulse_load(KEY_A, FRAME_A);
    repeat (120) @(posedge clk);
    push_words(a5_ref(KEY_B, FRAME_B));
    pulse_load(KEY_B, FRAME_B);
    run_to_done("restart", d0);

    // Reset after three accepted words, then a clean full run.
    push_words(w);
    w0 = word_cnt;
    pulse_load(KEY_A, FRAME_A);
    n = 0;
    while (word_cnt < w0 + 3 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check("three_words_seen", word_cnt - w0, 32'd3);
    reset_n = 1'b0;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_valid", {31'b0, out_valid}, 32'd0);
    check("midreset_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    push_words(w);
    d0 = done_cnt;
    pulse_load(KEY_A, FRAME_A);
    run_to_done("after_reset", d0);

    // All-zero key and frame give an all-zero stream.
    push_words('0);
    d0 = done_cnt;
    pulse_load(64'd0, 22'd0);
    run_to_done("zero_key", d0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/a5_keystream_gen.md
Name: a5_keystream_gen

Overview:
- A5/1 keystream generator core; sits directly upstream of the keystream FIFO behind the A5 Wishbone register interface.
- On a load pulse it runs the standard initialisation: 64 key clocks, 22 frame clocks, 100 discarded mixing clocks.
- It then produces KS_BITS keystream bits at one bit per cycle, packed into 32-bit words and pushed downstream over a valid/ready handshake.

Parameters:
- KS_BITS, 228, keystream bits produced per load (A→B 114 followed by B→A 114).
- MIX_CYCLES, 100, majority-clocked cycles discarded before output.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- load  input  1  single-cycle start pulse; samples key and frame
- key  input  64  session key; bit i is the i-th key bit clocked in
- frame  input  22  frame number; bit i is the i-th frame bit clocked in
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when the final word is accepted
- out_data  output  32  packed keystream word; first bit in [31]
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream can accept

Behaviour:
- Reset: asynchronous, active-low, on reset_n; clock is clk. Outputs and state on reset:
  - State IDLE; busy=0, done=0, out_valid=0, out_data=0.
  - R1, R2, R3, accumulator and counters all 0.
- Registers:
  - R1: 19b, feedback taps 13,16,17,18, clock bit 8.
  - R2: 22b, taps 20,21, clock bit 10.
  - R3: 23b, taps 7,20,21,22, clock bit 10.
  - Step: shift left by one; new bit0 = XOR of the register's taps.
- States: IDLE → KEY → FRAME → MIX → GEN → IDLE.
- IDLE:
  - load=1 captures key and frame, zeroes R1–R3, clears counters, goes to KEY.
- KEY, 64 cycles:
  - All three registers step each cycle.
  - After the step, bit0 of each register ^= key[i], for i=0..63.
- FRAME, 22 cycles:
  - Same as KEY, using frame[i], i=0..21.
- MIX, MIX_CYCLES cycles:
  - maj = majority of the three clock bits.
  - A register steps only if its clock bit == maj.
  - No output in this state.
- GEN:
  - Same majority clocking as MIX.
  - Keystream bit = R1[18]^R2[21]^R3[22], taken after the step.
  - The bit shifts into the accumulator MSB-first.
  - Bit counter runs 0..KS_BITS-1.
- Word hand-off:
  - Triggered when 32 bits are collected, or the last bit is produced.
  - The accumulator transfers to out_data and out_valid is set.
  - For a partial last word, valid bits are left-justified and the unused LSBs are 0. At 228 bits, word 7 holds 4 bits in [31:28].
- Output register:
  - One output register only.
  - A transfer is allowed if out_valid=0, or out_valid&out_ready in the same cycle.
  - If a transfer is blocked, GEN stalls: no register step, no counter advance, accumulator held.
- out_valid rules:
  - out_valid is held, with out_data stable, until out_ready=1.
  - It drops the cycle after acceptance unless a new word transfers in that same cycle.
- Latency:
  - With out_ready held high, first out_valid rises 64+22+MIX_CYCLES+32 = 218 cycles after the edge that samples load.
  - Subsequent words follow every 32 cycles.
- Completion:
  - After the last bit is produced, the FSM stays in GEN with no further stepping until the final word is accepted.
  - done then pulses for 1 cycle, coincident with the transition to IDLE.
- load while busy:
  - Aborts the current run and restarts from KEY with the new key/frame.
  - out_valid is cleared, and any pending word is discarded.
  - No done pulse is produced.
- reset_n asserted mid-run: immediate return to the reset values.
- out_ready in states other than GEN is ignored.

Decomposition:
- a5_pkg holds:
  - register lengths 19/22/23
  - tap masks
  - clock-bit indices 8/10/10
  - KEY_CYCLES=64, FRAME_CYCLES=22
  - state enum
- Sub-module a5_lfsr_core:
  - Holds R1–R3.
  - Inputs: clear, step_all, step_maj, inject bit.
  - Output: keystream bit.
  - Purely the register datapath, no sequencing.
- a5_keystream_gen holds the FSM, counters, packer and handshake.

Test Plan:
- Known vector: key=64'hEFCDAB8967452312, frame=22'h134, out_ready=1.
  - words 0..3 = 32'h534EAA58, 32'h2FE8151A, 32'hB6E1855A, 32'h728C093F.
  - First out_valid exactly 218 cycles after load.
  - 8 words total; done pulses once.
- Backpressure: same vector with out_ready toggled pseudo-randomly and held low for 50 cycles mid-word.
  - Identical 8-word sequence.
  - out_data stable while out_valid && !out_ready.
  - No words lost or duplicated.
- Last-word padding: word 7 [27:0] == 0 and matches the reference model in [31:28]; busy falls with done.
- Restart: pulse load with key A, then during MIX pulse load with key B.
  - Output equals a clean run with key B.
  - No done for run A.
- Reset mid-GEN: reset_n low for 1 cycle after 3 words accepted.
  - busy, out_valid, done = 0 immediately.
  - A subsequent load produces the correct full stream.
- All-zero key and frame: registers stay 0 and keystream is all 0; 8 words of 32'h0, done once.
